// File: rtl/eth_rx_multibuf.sv
// rtl/eth_rx_multibuf.sv - serial frame receiver into a ring of frame slots, read out over the CPU bus
// Optional station MAC filter: define ETH_RX_MAC_FILTER_EN.
module eth_rx_multibuf #(
    parameter int          SLOTS    = 2,
    parameter int          SLOT_AW  = 11,
    parameter logic [15:0] BUF_BASE = 16'hF000,
    parameter logic [15:0] CR_BASE  = 16'hFB00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        recv_sck,
    input  logic        recv_mosi,
    input  logic        n_recv_ss,
    input  logic [15:0] a,
    inout  wire  [7:0]  d,
    input  logic        n_oe,
    input  logic        n_we,
    output logic        n_rdy
);
    localparam int PW = $clog2(SLOTS);
    localparam int CW = PW + 1;
    localparam int AW = PW + SLOT_AW;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV, DROP} rx_state_t;

    // [0],[1] are the synchroniser stages, [2] is the edge-detect history
    logic [2:0]         sck_sr, ss_sr, oe_sr, we_sr;
    logic [1:0]         mosi_sr;

    rx_state_t          state;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic [SLOT_AW:0]   idx;
    logic               rx_trunc;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               ovf;
    logic [SLOT_AW-1:0] slot_len [SLOTS];
    logic               slot_trunc [SLOTS];

    logic               ram_we;
    logic [AW-1:0]      ram_waddr;
    logic [7:0]         ram_wdata, ram_q;
    logic [7:0]         mem [SLOTS << SLOT_AW];

    logic [7:0]         rd_reg, reg_rdata;
    logic               rd_is_ram;
    logic [15:0]        len16;

    logic sck_rise, ss_fall, ss_rise, oe_fall, we_fall;
    logic in_win, in_regs, sel, bus_start, cr_wr;
    logic full, frame_full, release_slot, commit, mac_ok;
    logic [7:0] rx_byte;

    assign sck_rise   = sck_sr[1] & ~sck_sr[2];
    assign ss_fall    = ~ss_sr[1] & ss_sr[2];
    assign ss_rise    = ss_sr[1] & ~ss_sr[2];
    assign oe_fall    = ~oe_sr[1] & oe_sr[2];
    assign we_fall    = ~we_sr[1] & we_sr[2];

    assign in_win     = (a[15:SLOT_AW] == BUF_BASE[15:SLOT_AW]);
    assign in_regs    = (a[15:4] == CR_BASE[15:4]);
    assign sel        = in_win | in_regs;
    assign bus_start  = (oe_fall | we_fall) & sel;
    assign cr_wr      = we_fall & in_regs & (a[3:0] == 4'h0);

    assign full         = (count != '0);
    assign frame_full   = (count == CW'(SLOTS));
    assign release_slot = cr_wr & d[0] & full;
    assign rx_byte      = {mosi_sr[1], shreg[7:1]};
    assign commit       = (state == RECV) & ss_rise & (idx != '0) & mac_ok;
    assign len16        = 16'(slot_len[rd_ptr]);

`ifdef ETH_RX_MAC_FILTER_EN
    logic [7:0] mac [6];
    logic [7:0] hdr [6];
    logic       hdr_is_mac, hdr_is_bcast;

    always_comb begin
        hdr_is_mac   = 1'b1;
        hdr_is_bcast = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (hdr[i] != mac[i]) hdr_is_mac = 1'b0;
            if (hdr[i] != 8'hFF) hdr_is_bcast = 1'b0;
        end
    end
    assign mac_ok = (idx >= (SLOT_AW+1)'(6)) & (hdr_is_mac | hdr_is_bcast);
`else
    assign mac_ok = 1'b1;
`endif

    always_comb begin
        reg_rdata = 8'h00;
        case (a[3:0])
            4'h0:    reg_rdata = {4'(count), 1'b0, slot_trunc[rd_ptr] & full, ovf, full};
            4'h2:    reg_rdata = len16[7:0];
            4'h3:    reg_rdata = len16[15:8];
            default: reg_rdata = 8'h00;
        endcase
`ifdef ETH_RX_MAC_FILTER_EN
        if (a[3] && a[2:0] <= 3'd5) reg_rdata = mac[a[2:0]];
`endif
    end

    assign d = (sel & ~n_oe) ? (rd_is_ram ? ram_q : rd_reg) : 8'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sr    <= '0;
            ss_sr     <= '0;
            mosi_sr   <= '0;
            oe_sr     <= '1;
            we_sr     <= '1;
            state     <= WAIT_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            idx       <= '0;
            rx_trunc  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            n_rdy     <= 1'b1;
            rd_reg    <= '0;
            rd_is_ram <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_len[i]   <= '0;
                slot_trunc[i] <= 1'b0;
            end
`ifdef ETH_RX_MAC_FILTER_EN
            for (int i = 0; i < 6; i++) begin
                mac[i] <= '0;
                hdr[i] <= '0;
            end
`endif
        end else begin
            sck_sr  <= {sck_sr[1:0], recv_sck};
            ss_sr   <= {ss_sr[1:0], n_recv_ss};
            oe_sr   <= {oe_sr[1:0], n_oe};
            we_sr   <= {we_sr[1:0], n_we};
            mosi_sr <= {mosi_sr[0], recv_mosi};
            ram_we  <= 1'b0;

            case (state)
                WAIT_IDLE: if (ss_sr[1]) state <= IDLE;
                IDLE: begin
                    if (ss_fall) begin
                        bit_cnt  <= '0;
                        idx      <= '0;
                        rx_trunc <= 1'b0;
                        state    <= frame_full ? DROP : RECV;
                    end
                end
                RECV: begin
                    if (ss_rise) begin
                        state <= IDLE;
                    end else if (sck_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            if (!idx[SLOT_AW]) begin
                                ram_we    <= 1'b1;
                                ram_waddr <= {wr_ptr, idx[SLOT_AW-1:0]};
                                ram_wdata <= rx_byte;
                                idx       <= idx + 1'b1;
`ifdef ETH_RX_MAC_FILTER_EN
                                if (idx < (SLOT_AW+1)'(6)) hdr[idx[2:0]] <= rx_byte;
`endif
                            end else begin
                                rx_trunc <= 1'b1;
                            end
                        end
                    end
                end
                DROP:    if (ss_rise) state <= IDLE;
                default: state <= WAIT_IDLE;
            endcase

            // idx saturates at the slot size, so idx-1 is already min(idx, size)-1
            if (commit) begin
                slot_len[wr_ptr]   <= SLOT_AW'(idx - 1'b1);
                slot_trunc[wr_ptr] <= rx_trunc;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (release_slot) rd_ptr <= rd_ptr + 1'b1;
            if (commit && !release_slot)      count <= count + 1'b1;
            else if (!commit && release_slot) count <= count - 1'b1;

            if (state == IDLE && ss_fall && frame_full) ovf <= 1'b1;
            else if (cr_wr && d[1])                     ovf <= 1'b0;

            if (bus_start) begin
                n_rdy     <= 1'b0;
                rd_reg    <= reg_rdata;
                rd_is_ram <= in_win;
            end else if (oe_sr[1] && we_sr[1]) begin
                n_rdy <= 1'b1;
            end
`ifdef ETH_RX_MAC_FILTER_EN
            if (we_fall && in_regs && a[3] && a[2:0] <= 3'd5) mac[a[2:0]] <= d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (oe_fall && in_win) ram_q <= mem[{rd_ptr, a[SLOT_AW-1:0]}];
    end
endmodule

// File: tb/tb_eth_rx_multibuf.sv
// tb/tb_eth_rx_multibuf.sv - scoreboard bench with a frame-level reference model for eth_rx_multibuf
module tb_eth_rx_multibuf;
    localparam int          SLOTS   = 2;
    localparam int          SLOT_AW = 4;
    localparam int          SZ      = 1 << SLOT_AW;
    localparam logic [15:0] BUF     = 16'hF000;
    localparam logic [15:0] CR      = 16'hFB00;

    logic        clk = 1'b0, rst = 1'b1;
    logic        recv_sck = 1'b0, recv_mosi = 1'b0, n_recv_ss = 1'b1;
    logic [15:0] a = 16'h0000;
    logic        n_oe = 1'b1, n_we = 1'b1;
    wire         n_rdy;
    wire  [7:0]  d;
    logic        tb_drv = 1'b0;
    logic [7:0]  tb_wdata = 8'h00;

    assign d = tb_drv ? tb_wdata : 8'bz;

    eth_rx_multibuf #(.SLOTS(SLOTS), .SLOT_AW(SLOT_AW), .BUF_BASE(BUF), .CR_BASE(CR)) dut (
        .clk(clk), .rst(rst), .recv_sck(recv_sck), .recv_mosi(recv_mosi), .n_recv_ss(n_recv_ss),
        .a(a), .d(d), .n_oe(n_oe), .n_we(n_we), .n_rdy(n_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    typedef struct {
        int         len;
        logic [7:0] b [24];
    } frame_t;

    frame_t     mdl_q[$];
    logic       mdl_ovf = 1'b0;
    logic [7:0] mdl_mac [6] = '{default: 8'h00};

    logic [7:0] exp_q[$];
    string      name_q[$];

    localparam logic [7:0] SINGLE [10] = '{8'hFE, 8'hFA, 8'hF6, 8'hF2, 8'hEE, 8'hEA, 8'hAA, 8'h55, 8'h73, 8'h87};

    function automatic logic accept(input frame_t f);
`ifdef ETH_RX_MAC_FILTER_EN
        logic m = 1'b1, bc = 1'b1;
        if (f.len < 6) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (f.b[i] != mdl_mac[i]) m = 1'b0;
            if (f.b[i] != 8'hFF) bc = 1'b0;
        end
        return m | bc;
`else
        return f.len > 0;
`endif
    endfunction

    // Monitor: every falling n_rdy during a read is matched against the oldest expectation.
    logic rdy_prev = 1'b1;
    always @(negedge clk) begin
        logic [7:0] e;
        string      nm;
        if (n_rdy === 1'b0 && rdy_prev && n_oe === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read addr=%h got=%h", a, d);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (d !== e) begin
                    errors++;
                    $display("FAIL %s addr=%h got=%h exp=%h", nm, a, d, e);
                end
            end
        end
        rdy_prev = (n_rdy !== 1'b0);
    end

    task automatic wait_rdy_high(input string nm);
        int n = 0;
        while (n_rdy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        if (n_rdy !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_release n_rdy=%b exp=1", nm, n_rdy);
        end
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [7:0] exp, input string nm);
        int lat = 0;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk); a = addr;
        @(negedge clk); n_oe = 1'b0;
        while (n_rdy !== 1'b0 && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s_latency got=%0d exp=3", nm, lat);
            if (n_rdy !== 1'b0) begin
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
        end
        @(negedge clk); n_oe = 1'b1;
        wait_rdy_high(nm);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] v);
        int lat = 0;
        @(negedge clk); a = addr; tb_wdata = v; tb_drv = 1'b1;
        @(negedge clk); n_we = 1'b0;
        while (n_rdy !== 1'b0 && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL write_latency addr=%h got=%0d exp=3", addr, lat);
        end
        @(negedge clk); n_we = 1'b1;
        wait_rdy_high("write");
        tb_drv = 1'b0;
        if (addr == CR) begin
            if (v[0] && mdl_q.size() > 0) mdl_q.delete(0);
            if (v[1]) mdl_ovf = 1'b0;
        end
`ifdef ETH_RX_MAC_FILTER_EN
        if (addr >= CR + 16'd8 && addr <= CR + 16'd13) mdl_mac[addr - CR - 16'd8] = v;
`endif
    endtask

    task automatic send_bit(input logic bv);
        recv_mosi = bv;
        #30 recv_sck = 1'b1;
        #30 recv_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_frame(input frame_t f, input int extra_bits);
        n_recv_ss = 1'b0;
        #100;
        for (int i = 0; i < f.len; i++) send_byte(f.b[i]);
        for (int i = 0; i < extra_bits; i++) send_bit(1'($urandom_range(0, 1)));
        #100 n_recv_ss = 1'b1;
        #150;
        if (mdl_q.size() == SLOTS) mdl_ovf = 1'b1;
        else if (accept(f)) mdl_q.push_back(f);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (n_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_n_rdy got=%b exp=1", n_rdy);
        end
        rst = 1'b0;
        mdl_q.delete();
        mdl_ovf = 1'b0;
        for (int i = 0; i < 6; i++) mdl_mac[i] = 8'h00;
    endtask

    task automatic check_all(input logic full_data);
        int         cnt = mdl_q.size();
        int         n;
        logic       tr;
        logic [7:0] cr;
        tr = (cnt != 0) && (mdl_q[0].len > SZ);
        cr = {4'(cnt), 1'b0, tr, mdl_ovf, cnt != 0};
        bus_read(CR, cr, "cr");
        if (cnt > 0) begin
            n = (mdl_q[0].len > SZ) ? SZ : mdl_q[0].len;
            bus_read(CR + 16'd2, 8'(n - 1), "len_lo");
            bus_read(CR + 16'd3, 8'h00, "len_hi");
            if (full_data) begin
                for (int i = 0; i < n; i++) bus_read(BUF + 16'(i), mdl_q[0].b[i], "data");
            end else begin
                bus_read(BUF, mdl_q[0].b[0], "data_first");
                bus_read(BUF + 16'(n - 1), mdl_q[0].b[n - 1], "data_last");
            end
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        int     kind;
        f.len = $urandom_range(0, 20);
        for (int i = 0; i < 24; i++) f.b[i] = 8'($urandom);
        kind = $urandom_range(0, 2);
        for (int i = 0; i < 6; i++) begin
            if (kind == 0) f.b[i] = mdl_mac[i];
            else if (kind == 1) f.b[i] = 8'hFF;
        end
        return f;
    endfunction

    initial begin
        #900_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        do_reset();
        check_all(1'b1);

        // Reset in the middle of a frame: the tail must not commit.
        for (int i = 0; i < 24; i++) f.b[i] = 8'h3C;
        n_recv_ss = 1'b0; #100;
        send_byte(8'h11); send_byte(8'h22);
        do_reset();
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        #100 n_recv_ss = 1'b1; #150;
        bus_read(CR, 8'h00, "cr_after_rst");

        for (int i = 0; i < 6; i++) bus_write(CR + 16'(8 + i), SINGLE[i]);
        for (int i = 0; i < 6; i++) bus_read(CR + 16'(8 + i), mdl_mac[i], "mac_reg");
        bus_read(CR + 16'd1, 8'h00, "unused_reg");

        f.len = 10;
        for (int i = 0; i < 10; i++) f.b[i] = SINGLE[i];
        send_frame(f, 0);
        bus_read(CR, 8'h11, "cr_single");
        check_all(1'b1);
        bus_write(CR, 8'h01);
        check_all(1'b1);

        f.len = 3;
        for (int i = 0; i < 3; i++) f.b[i] = 8'(i + 1);
        send_frame(f, 0);
        f.len = 5;
        for (int i = 0; i < 5; i++) f.b[i] = 8'h10 + 8'(i);
        send_frame(f, 0);
        check_all(1'b1);
        bus_write(CR, 8'h01);
        check_all(1'b1);
        bus_write(CR, 8'h01);
        check_all(1'b1);

        // Overflow: third frame with both slots occupied.
        for (int k = 0; k < 3; k++) begin
            f.len = 8;
            for (int i = 0; i < 8; i++) f.b[i] = (i < 6) ? 8'hFF : 8'(k);
            send_frame(f, 0);
        end
        check_all(1'b0);
        bus_write(CR, 8'h02);
        check_all(1'b0);
        bus_write(CR, 8'h01);
        bus_write(CR, 8'h01);
        check_all(1'b0);

        // Truncation beyond the slot size.
        f.len = 20;
        for (int i = 0; i < 20; i++) f.b[i] = 8'(i);
        for (int i = 0; i < 6; i++) f.b[i] = 8'hFF;
        send_frame(f, 0);
        check_all(1'b1);
        bus_write(CR, 8'h01);

        // Degenerate frames.
        f.len = 0;
        send_frame(f, 0);
        check_all(1'b0);
        f.len = 2; f.b[0] = 8'hA5; f.b[1] = 8'h5A;
        send_frame(f, 3);
        check_all(1'b1);
        bus_write(CR, 8'h01);

        // Destination filter cases.
        f.len = 9;
        for (int i = 0; i < 9; i++) f.b[i] = 8'h40 + 8'(i);
        for (int i = 0; i < 6; i++) f.b[i] = (i == 0) ? 8'h02 : ((i == 5) ? 8'h01 : 8'h00);
        send_frame(f, 0);
        check_all(1'b0);
        for (int i = 0; i < 6; i++) f.b[i] = 8'hFF;
        send_frame(f, 0);
        check_all(1'b0);
        bus_write(CR, 8'h03);
        bus_write(CR, 8'h01);
        check_all(1'b0);

        for (int r = 0; r < 25; r++) begin
            send_frame(rand_frame(), $urandom_range(0, 7));
            check_all(1'(r % 4 == 0));
            if ($urandom_range(0, 1) == 1) bus_write(CR, 8'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) check_all(1'b0);
        end
        bus_write(CR, 8'h03);
        bus_write(CR, 8'h01);
        check_all(1'b0);

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_rx_multibuf.md
# eth_rx_multibuf

Multi-slot successor to the single-buffer Ethernet receive system. It deserialises frames arriving on the LSB-first serial link (`recv_sck`/`recv_mosi`/`n_recv_ss`) into a ring of `SLOTS` frame buffers. The CPU reads the buffers through the memory-mapped bus (`a`/`d`/`n_oe`/`n_we`/`n_rdy`), so the CPU can drain one frame while later frames arrive. Everything runs in one clock domain; link and bus inputs pass through 2-FF synchronisers.

## Interface
- `SLOTS`, 2, number of frame slots; power of 2, 2..8.
- `SLOT_AW`, 11, log2 of slot size in bytes (2048).
- `BUF_BASE`, 16'hF000, base of the read-slot data window, aligned to 2^SLOT_AW.
- `CR_BASE`, 16'hFB00, base of the register block.
- `clk`  in  1  system clock; at least 4× the `recv_sck` frequency.
- `rst`  in  1  asynchronous, active-high reset.
- `recv_sck`  in  1  serial clock; data sampled on rising edge.
- `recv_mosi`  in  1  serial data, LSB first.
- `n_recv_ss`  in  1  frame envelope, active low.
- `a`  in  16  CPU address.
- `d`  inout  8  CPU data. Driven only while selected and `n_oe`=0; otherwise hi-Z.
- `n_oe`  in  1  read strobe, active low.
- `n_we`  in  1  write strobe, active low.
- `n_rdy`  out  1  access complete, active low. Open while unselected.

## Operation
- **Registers, as offsets from CR_BASE:**
  - +0 CR, read: {count[3:0], 0, trunc, ovf, full}.
    - full = count≠0.
    - trunc = read slot was truncated.
    - ovf = sticky frame-dropped flag.
  - +0 CR, write: bit0=1 releases the read slot (ignored if count=0); bit1=1 clears ovf.
  - +2 LEN_LO, +3 LEN_HI: last byte index of the read slot, i.e. byte count−1, zero-extended to 16 bits.
  - `BUF_BASE`+n: byte n of the read slot. Contents beyond LEN are undefined.
  - Other addresses in the block read 0; writes to them are ignored.
- **Storage:** synchronous RAM of SLOTS·2^SLOT_AW bytes. Each slot also stores LEN and trunc.
- **Pointers:** wr_ptr and rd_ptr wrap modulo SLOTS. count ranges 0..SLOTS.
- **Receiver FSM:**
  - WAIT_IDLE → IDLE: on synchronised `n_recv_ss` high.
  - IDLE → RECV: on `n_recv_ss` fall, if count<SLOTS.
  - IDLE → DROP: on `n_recv_ss` fall, if count=SLOTS; ovf is set.
  - RECV: a bit counter collects 8 bits, then writes the byte at wr_ptr:idx and increments idx.
    - While idx=2^SLOT_AW, further bytes are discarded and trunc is set.
  - RECV → IDLE on `n_recv_ss` rise:
    - If idx≥1: commit LEN=min(idx,2^SLOT_AW)−1, advance wr_ptr, increment count.
    - If idx=0: discard. An incomplete trailing byte is always discarded.
  - DROP → IDLE on `n_recv_ss` rise.
- **Bus access:** the falling edge of the synchronised strobe starts one access. `n_rdy` goes low once data or write is complete and stays low until the strobe rises. Each write takes effect exactly once per strobe.
- **Simultaneous commit and release in one cycle:** both pointers advance and count is unchanged.
- **Reset:**
  - count=0, pointers=0, ovf=0, FSM=WAIT_IDLE, `n_rdy`=1, `d` hi-Z.
  - A frame in progress is lost. Bits arriving before `n_recv_ss` is seen high are ignored.

## Timing
- Commit is visible in CR ≤3 clk after the `n_recv_ss` rise at the pin.
- Read: `n_rdy` falls 3 clk after the `n_oe` fall at the pin (2 sync + 1 RAM cycle). `d` is valid whenever `n_rdy`=0.
- Write: `n_rdy` falls 3 clk after the `n_we` fall at the pin. The register update happens in the same cycle `n_rdy` falls.
- `n_rdy` returns high ≤3 clk after the strobe rises.
- The RAM write of a byte occurs 1 clk after its 8th synchronised `recv_sck` rise.

## Configuration
- `ETH_RX_MAC_FILTER_EN` defined:
  - Registers CR_BASE+8..+13 hold the station MAC, byte 0 at +8. Reset value is 0; the registers are read/write.
  - At commit, a frame is discarded (no commit, ovf unaffected) unless it has ≥6 bytes and bytes 0..5 equal the station MAC or FF:FF:FF:FF:FF:FF.
- Not defined: every non-empty frame commits. +8..+13 read 0 and writes to them are ignored.

## Test plan
- **Single frame:** SLOTS=2, 10 bytes FE,FA,F6,F2,EE,EA,AA,55,73,87 → CR=0x11, LEN_LO=9, LEN_HI=0, F000..F009 match the sent bytes.
- **Two frames:** frames of 3 bytes (01,02,03) then 5 bytes (10..14) → CR=0x21, LEN=2. Write CR=0x01 → CR=0x11, LEN=4, F000=0x10, F004=0x14. Write 0x01 again → CR=0x00.
- **Overflow:** SLOTS=2, three frames with no release → CR=0x23, third frame absent. Write CR=0x02 → CR=0x21.
- **Truncation:** SLOT_AW=4, 20 bytes 00..13 → CR=0x15, LEN=15, F00F=0x0F.
- **Degenerate frames and reset:** 0-bit `n_recv_ss` pulse → CR=0x00. Frame of 2 bytes + 3 bits → LEN=1. `rst` mid-frame, then the frame continues → no commit, CR=0x00; the next full frame commits normally.
- **MAC filter** (`ETH_RX_MAC_FILTER_EN` defined, MAC set to FE:FA:F6:F2:EE:EA):
  - Matching frame → CR=0x11.
  - Frame with destination 02:00:00:00:00:01 → CR stays 0x11.
  - Broadcast frame → CR=0x21.
